// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed/unsigned selected per operand pair.
// Latency WIDTH+2 edges from accept to out_valid; result held until out_ready, inputs refused while busy.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int W1 = WIDTH + 1;
    localparam int AW = W1 + 1;
    localparam int CW = $clog2(W1 + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      a_q, a_d;
    logic [W1-1:0]      q_q, q_d;
    logic [W1-1:0]      m_q, m_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [AW-1:0]      m_ext;
    logic [AW-1:0]      a_sum;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        m_ext = {m_q[W1-1], m_q};
        case ({q_q[0], qm1_q})
            2'b01:   a_sum = a_q + m_ext;
            2'b10:   a_sum = a_q - m_ext;
            default: a_sum = a_q;
        endcase

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = '0;
                    q_d     = {in_signed & multiplier[WIDTH-1], multiplier};
                    m_d     = {in_signed & multiplicand[WIDTH-1], multiplicand};
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(W1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    // Low 2*WIDTH bits of {A,Q}; Q is one bit wider than an operand.
                    prod_d  = {a_q[WIDTH-2:0], q_q};
                    state_d = DONE;
                end else begin
                    a_d   = {a_sum[AW-1], a_sum[AW-1:1]};
                    q_d   = {a_sum[0], q_q[W1-1:1]};
                    qm1_d = q_q[0];
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = prod_q;
endmodule
